// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and default-slave state type for the interconnect.
// Holds transfer type, response codes and the error-responder FSM states.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR for active transfers to unmapped space, with error count/address log.
// Latency: ERROR completes in 2 data-phase cycles; idle/busy transfers get a zero-wait OKAY.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hready,
  input  logic             no_hit,
  input  logic             active,
  input  logic [31:0]      haddr,
  input  logic             err_clr,
  output logic             ready,
  output logic             resp,
  output logic [CNT_W-1:0] err_cnt,
  output logic [31:0]      err_addr
);

  ds_state_t state, state_nxt;
  logic      start_err;
  logic      log_err;

  assign start_err = hready & no_hit & active;
  assign log_err   = start_err & (state != DS_ERR1);

  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    resp      = HRESP_OKAY;
    case (state)
      DS_IDLE: if (start_err) state_nxt = DS_ERR1;
      DS_ERR1: begin
        ready     = 1'b0;
        resp      = HRESP_ERROR;
        state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        resp      = HRESP_ERROR;
        state_nxt = start_err ? DS_ERR1 : DS_IDLE;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DS_IDLE;
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      state <= state_nxt;
      // Clear wins over a coincident new error.
      if (err_clr)
        err_cnt <= '0;
      else if (log_err && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
      if (log_err)
        err_addr <= haddr;
    end
  end

endmodule

// File: rtl/ahb_lite_interconnect_param.sv
// Single-master AHB-Lite interconnect: base/mask decode, registered data-phase mux, default slave, stall watchdog.
// Zero added wait states; master stalls only on the selected slave's HREADYOUT or the default slave's ERROR.
module ahb_lite_interconnect_param
  import ahb_pkg::*;
#(
  parameter int                   NSLV      = 6,
  parameter logic [NSLV*32-1:0]   BASE_ADDR = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0]   ADDR_MASK = {NSLV{32'hF000_0000}},
  parameter int                   TIMEOUT   = 256,
  parameter int                   CNT_W     = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [31:0]          HADDR,
  input  logic [2:0]           HBURST,
  input  logic                 HMASTLOCK,
  input  logic [3:0]           HPROT,
  input  logic [2:0]           HSIZE,
  input  logic [1:0]           HTRANS,
  input  logic [31:0]          HWDATA,
  input  logic                 HWRITE,
  output logic                 HREADY,
  output logic [31:0]          HRDATA,
  output logic                 HRESP,
  output logic [NSLV-1:0]      HSEL_S,
  output logic                 HREADY_S,
  input  logic [NSLV-1:0]      HREADYOUT_S,
  input  logic [NSLV-1:0]      HRESP_S,
  input  logic [NSLV*32-1:0]   HRDATA_S,
  input  logic                 ERR_CLR,
  output logic [CNT_W-1:0]     ERR_CNT,
  output logic [31:0]          ERR_ADDR,
  output logic                 STALL_FLAG
);

  localparam int              SW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0]   TO_LIM = SW'(TIMEOUT);

  logic [NSLV-1:0] hit;
  logic [NSLV-1:0] hsel;
  logic            no_hit;
  logic [NSLV:0]   dsel;
  logic            ds_ready;
  logic            ds_resp;
  logic            real_dphase;
  logic            stall_now;
  logic [SW-1:0]   stall_cnt;
  logic            unused_inputs;

  assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT, HSIZE, HWDATA, HWRITE, HTRANS[0]};

  // Lowest index wins when regions overlap.
  for (genvar i = 0; i < NSLV; i++) begin : g_dec
    assign hit[i] = ((HADDR & ADDR_MASK[32*i +: 32]) == BASE_ADDR[32*i +: 32]);
    if (i == 0) begin : g_first
      assign hsel[i] = hit[i];
    end else begin : g_rest
      assign hsel[i] = hit[i] & ~(|hit[i-1:0]);
    end
  end

  assign no_hit   = ~(|hit);
  assign HSEL_S   = hsel;
  assign HREADY_S = HREADY;

  always_ff @(posedge HCLK) begin
    if (HRESET)
      dsel <= '0;
    else if (HREADY)
      dsel <= {no_hit, hsel};
  end

  // dsel is one-hot or zero, so an OR-mux is sufficient; all-zero only occurs straight after reset.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    if (dsel[NSLV]) begin
      HREADY = ds_ready;
      HRESP  = ds_resp;
    end
    for (int i = 0; i < NSLV; i++) begin
      if (dsel[i]) begin
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
        HRDATA = HRDATA_S[32*i +: 32];
      end
    end
  end

  ahb_default_slave #(
    .CNT_W (CNT_W)
  ) u_default_slave (
    .clk      (HCLK),
    .rst      (HRESET),
    .hready   (HREADY),
    .no_hit   (no_hit),
    .active   (HTRANS[1]),
    .haddr    (HADDR),
    .err_clr  (ERR_CLR),
    .ready    (ds_ready),
    .resp     (ds_resp),
    .err_cnt  (ERR_CNT),
    .err_addr (ERR_ADDR)
  );

  assign real_dphase = |dsel[NSLV-1:0];
  assign stall_now   = ~HREADY & real_dphase;

  // Counter saturates at the limit; the flag fires on the stall cycle that reaches the limit.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      stall_cnt  <= '0;
      STALL_FLAG <= 1'b0;
    end else begin
      if (HREADY)
        stall_cnt <= '0;
      else if (stall_now && (stall_cnt != TO_LIM))
        stall_cnt <= stall_cnt + 1'b1;
      if (ERR_CLR)
        STALL_FLAG <= 1'b0;
      else if ((TIMEOUT != 0) && stall_now && (stall_cnt == TO_LIM - 1'b1))
        STALL_FLAG <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_lite_interconnect_param.sv
// Bench for the AHB-Lite interconnect: decode table, directed multi-cycle sequences, random run vs. reference model.
// Instance A: linear map, TIMEOUT=8, 16-bit counter; instance B: overlapping map, watchdog off, 4-bit counter.
module tb_ahb_lite_interconnect_param;

  localparam int N = 6;
  localparam logic [N*32-1:0] BASE_A = {32'h5000_0000, 32'h4000_0000, 32'h3000_0000,
                                        32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [N*32-1:0] MASK_A = {N{32'hF000_0000}};
  localparam logic [N*32-1:0] BASE_B = {32'h5000_0000, 32'h4000_0000, 32'h0000_1000,
                                        32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [N*32-1:0] MASK_B = {32'hF000_0000, 32'hF000_0000, 32'hFFFF_F000,
                                        32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [31:0]   HADDR;
  logic [2:0]    HBURST;
  logic          HMASTLOCK;
  logic [3:0]    HPROT;
  logic [2:0]    HSIZE;
  logic [1:0]    HTRANS;
  logic [31:0]   HWDATA;
  logic          HWRITE;
  logic [N-1:0]  HREADYOUT_S;
  logic [N-1:0]  HRESP_S;
  logic [N*32-1:0] HRDATA_S;
  logic          ERR_CLR;

  logic          a_hready, a_hresp, a_hready_s, a_stall;
  logic [31:0]   a_hrdata, a_err_addr;
  logic [N-1:0]  a_hsel;
  logic [15:0]   a_err_cnt;
  logic          b_hready, b_hresp, b_hready_s, b_stall;
  logic [31:0]   b_hrdata, b_err_addr;
  logic [N-1:0]  b_hsel;
  logic [3:0]    b_err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_interconnect_param #(
    .NSLV(N), .BASE_ADDR(BASE_A), .ADDR_MASK(MASK_A), .TIMEOUT(8), .CNT_W(16)
  ) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
    .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HREADY(a_hready), .HRDATA(a_hrdata), .HRESP(a_hresp), .HSEL_S(a_hsel),
    .HREADY_S(a_hready_s), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
    .ERR_CLR(ERR_CLR), .ERR_CNT(a_err_cnt), .ERR_ADDR(a_err_addr), .STALL_FLAG(a_stall)
  );

  ahb_lite_interconnect_param #(
    .NSLV(N), .BASE_ADDR(BASE_B), .ADDR_MASK(MASK_B), .TIMEOUT(0), .CNT_W(4)
  ) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
    .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HREADY(b_hready), .HRDATA(b_hrdata), .HRESP(b_hresp), .HSEL_S(b_hsel),
    .HREADY_S(b_hready_s), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
    .ERR_CLR(ERR_CLR), .ERR_CNT(b_err_cnt), .ERR_ADDR(b_err_addr), .STALL_FLAG(b_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge HCLK);
  endtask

  task automatic present(input logic [31:0] addr, input logic [1:0] trans);
    HADDR  = addr;
    HTRANS = trans;
  endtask

  typedef struct {
    logic [31:0]  addr;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
  } dec_vec_t;
  dec_vec_t dtab[7];

  // Reference model state (instance A): who owns the data phase and how far into an ERROR we are.
  int          m_own;
  int          m_err;
  int          m_run;
  logic [15:0] m_cnt;
  logic [31:0] m_addr;
  logic        m_flag;

  function automatic int decode_a(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & 32'hF000_0000) == 32'(i) * 32'h1000_0000) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_err = 0; m_run = 0; m_cnt = '0; m_addr = '0; m_flag = 1'b0;
  endtask

  task automatic model_cycle();
    int w;
    logic er, es, start;
    logic [31:0] ed;
    logic [N-1:0] esel;
    w    = decode_a(HADDR);
    esel = (w < 0) ? '0 : N'(1) << w;
    if (m_own < 0) begin
      er = 1'b1; es = 1'b0; ed = '0;
    end else if (m_own < N) begin
      er = HREADYOUT_S[m_own]; es = HRESP_S[m_own]; ed = HRDATA_S[m_own*32 +: 32];
    end else begin
      er = (m_err != 1); es = (m_err != 0); ed = '0;
    end
    chk("rnd_hsel", 32'(a_hsel), 32'(esel));
    chk("rnd_hready", 32'(a_hready), 32'(er));
    chk("rnd_hresp", 32'(a_hresp), 32'(es));
    chk("rnd_hrdata", a_hrdata, ed);
    chk("rnd_err_cnt", 32'(a_err_cnt), 32'(m_cnt));
    chk("rnd_err_addr", a_err_addr, m_addr);
    chk("rnd_stall", 32'(a_stall), 32'(m_flag));
    if (HRESET) begin
      model_reset();
    end else begin
      start = er && (w < 0) && HTRANS[1] && (m_err != 1);
      if (er) m_run = 0;
      else if (m_own >= 0 && m_own < N) m_run = m_run + 1;
      if (ERR_CLR) m_flag = 1'b0;
      else if (!er && m_own >= 0 && m_own < N && m_run == 8) m_flag = 1'b1;
      if (ERR_CLR) m_cnt = '0;
      else if (start && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (start) m_addr = HADDR;
      m_err = (m_err == 1) ? 2 : (start ? 1 : 0);
      if (er) m_own = (w < 0) ? N : w;
    end
  endtask

  initial begin
    dtab[0] = '{32'h2000_0010, 6'b000100, 6'b000100};
    dtab[1] = '{32'h0000_1000, 6'b000001, 6'b000001};
    dtab[2] = '{32'h3000_0000, 6'b001000, 6'b000000};
    dtab[3] = '{32'h5FFF_FFFC, 6'b100000, 6'b100000};
    dtab[4] = '{32'h9000_0000, 6'b000000, 6'b000000};
    dtab[5] = '{32'hF000_0000, 6'b000000, 6'b000000};
    dtab[6] = '{32'h6000_0000, 6'b000000, 6'b000000};

    HRESET = 1'b1; HBURST = '0; HMASTLOCK = 1'b0; HPROT = '0; HSIZE = 3'd2;
    HWDATA = '0; HWRITE = 1'b0; ERR_CLR = 1'b0; HREADYOUT_S = '1; HRESP_S = '0;
    present(32'h0, 2'b00);
    for (int i = 0; i < N; i++) HRDATA_S[32*i +: 32] = 32'hA0A0_0000 + 32'(i);
    nxt(); nxt();
    HRESET = 1'b0;
    #1;
    chk("rst_hready", 32'(a_hready), 32'h1);
    chk("rst_hresp", 32'(a_hresp), 32'h0);
    chk("rst_hrdata", a_hrdata, 32'h0);
    chk("rst_err_cnt", 32'(a_err_cnt), 32'h0);
    chk("rst_err_addr", a_err_addr, 32'h0);
    chk("rst_stall", 32'(a_stall), 32'h0);

    for (int i = 0; i < 7; i++) begin
      present(dtab[i].addr, 2'b00);
      #1;
      chk("dec_a", 32'(a_hsel), 32'(dtab[i].sel_a));
      chk("dec_b", 32'(b_hsel), 32'(dtab[i].sel_b));
    end
    nxt();

    // Simple read from slave 2.
    HRDATA_S[64 +: 32] = 32'hDEAD_BEEF;
    present(32'h2000_0010, 2'b10);
    #1 chk("rd_hsel", 32'(a_hsel), 32'h04);
    nxt(); present(32'h0, 2'b00);
    #1;
    chk("rd_data", a_hrdata, 32'hDEAD_BEEF);
    chk("rd_hready", 32'(a_hready), 32'h1);
    chk("rd_hresp", 32'(a_hresp), 32'h0);
    nxt();

    // Slave 4 stalls three cycles with the next address pipelined behind it.
    HRDATA_S[128 +: 32] = 32'h4444_4444;
    present(32'h4000_0000, 2'b10);
    nxt();
    HREADYOUT_S[4] = 1'b0;
    present(32'h2000_0000, 2'b10);
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall4_low", 32'(a_hready), 32'h0);
      nxt();
    end
    HREADYOUT_S[4] = 1'b1;
    HRDATA_S[64 +: 32] = 32'h2222_2222;
    #1;
    chk("stall4_rel", 32'(a_hready), 32'h1);
    chk("stall4_data", a_hrdata, 32'h4444_4444);
    nxt(); present(32'h0, 2'b00);
    #1 chk("pipe_data", a_hrdata, 32'h2222_2222);
    nxt();

    // Single unmapped NONSEQ, then an IDLE to the same hole.
    present(32'h9000_0000, 2'b10);
    nxt(); present(32'h0, 2'b00);
    #1;
    chk("err1_hready", 32'(a_hready), 32'h0);
    chk("err1_hresp", 32'(a_hresp), 32'h1);
    chk("err1_hrdata", a_hrdata, 32'h0);
    chk("err1_cnt", 32'(a_err_cnt), 32'h1);
    chk("err1_addr", a_err_addr, 32'h9000_0000);
    nxt(); present(32'h9000_0000, 2'b00);
    #1;
    chk("err2_hready", 32'(a_hready), 32'h1);
    chk("err2_hresp", 32'(a_hresp), 32'h1);
    nxt();
    #1;
    chk("idle_unmap_hready", 32'(a_hready), 32'h1);
    chk("idle_unmap_hresp", 32'(a_hresp), 32'h0);
    chk("idle_unmap_cnt", 32'(a_err_cnt), 32'h1);
    nxt();

    // Back-to-back unmapped transfers; the second is accepted in ERR2.
    present(32'h7000_0004, 2'b10);
    nxt(); present(32'h8000_0008, 2'b10);
    #1;
    chk("b2b_e1", 32'(a_hready), 32'h0);
    chk("b2b_cnt2", 32'(a_err_cnt), 32'h2);
    nxt();
    #1 chk("b2b_e2", 32'({a_hready, a_hresp}), 32'h3);
    nxt(); present(32'h0, 2'b00);
    #1;
    chk("b2b_e1_again", 32'({a_hready, a_hresp}), 32'h1);
    chk("b2b_cnt3", 32'(a_err_cnt), 32'h3);
    chk("b2b_addr", a_err_addr, 32'h8000_0008);
    nxt(); nxt();
    #1 chk("b2b_done", 32'({a_hready, a_hresp}), 32'h2);

    // Fourteen more errors: B's 4-bit counter saturates, A keeps counting.
    present(32'hA000_0000, 2'b11);
    repeat (28) nxt();
    present(32'h0, 2'b00);
    #1 chk("sat_err2", 32'({a_hready, a_hresp}), 32'h3);
    nxt();
    #1;
    chk("sat_cnt_a", 32'(a_err_cnt), 32'd17);
    chk("sat_cnt_b", 32'(b_err_cnt), 32'hF);
    nxt();

    // Clear coincident with a new error.
    present(32'hB000_0000, 2'b10);
    ERR_CLR = 1'b1;
    nxt(); ERR_CLR = 1'b0; present(32'h0, 2'b00);
    #1;
    chk("clr_cnt_a", 32'(a_err_cnt), 32'h0);
    chk("clr_cnt_b", 32'(b_err_cnt), 32'h0);
    chk("clr_addr", a_err_addr, 32'hB000_0000);
    chk("clr_e1", 32'({a_hready, a_hresp}), 32'h1);
    nxt(); nxt();

    // Watchdog: 7-cycle stall stays quiet, 8-cycle stall trips A, 1000-cycle stall leaves B quiet.
    present(32'h1000_0000, 2'b10);
    nxt(); present(32'h0, 2'b00); HREADYOUT_S[1] = 1'b0;
    repeat (7) nxt();
    HREADYOUT_S[1] = 1'b1;
    #1 chk("wd_7", 32'(a_stall), 32'h0);
    present(32'h1000_0000, 2'b10);
    nxt(); present(32'h0, 2'b00); HREADYOUT_S[1] = 1'b0;
    repeat (8) nxt();
    HREADYOUT_S[1] = 1'b1;
    #1 chk("wd_8", 32'(a_stall), 32'h1);
    nxt();
    #1 chk("wd_sticky", 32'(a_stall), 32'h1);
    present(32'h1000_0000, 2'b10);
    nxt(); present(32'h0, 2'b00); HREADYOUT_S[1] = 1'b0;
    repeat (1000) nxt();
    #1;
    chk("wd_long_hready", 32'(b_hready), 32'h0);
    chk("wd_off_b", 32'(b_stall), 32'h0);
    HREADYOUT_S[1] = 1'b1;
    nxt(); ERR_CLR = 1'b1;
    nxt(); ERR_CLR = 1'b0;
    #1 chk("wd_clr", 32'(a_stall), 32'h0);

    // Reset during ERR1 abandons the error.
    present(32'hC000_0000, 2'b10);
    nxt(); present(32'hC000_0000, 2'b00);
    #1 chk("rst_e1_pre", 32'(a_hready), 32'h0);
    HRESET = 1'b1;
    nxt(); HRESET = 1'b0;
    #1;
    chk("rst_e1_hready", 32'(a_hready), 32'h1);
    chk("rst_e1_hresp", 32'(a_hresp), 32'h0);
    chk("rst_e1_cnt", 32'(a_err_cnt), 32'h0);
    nxt();
    #1 chk("rst_e1_idle", 32'({a_hready, a_hresp}), 32'h2);

    // Randomised run against the reference model.
    HRESET = 1'b1;
    nxt(); HRESET = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      HADDR   = {4'($urandom_range(0, 9)), 28'($urandom)};
      HTRANS  = 2'($urandom);
      HRESET  = ($urandom_range(0, 299) == 0);
      ERR_CLR = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        HREADYOUT_S[i] = ($urandom_range(0, 3) != 0);
        HRESP_S[i]     = ($urandom_range(0, 7) == 0);
        HRDATA_S[32*i +: 32] = $urandom;
      end
      #1 model_cycle();
      nxt();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
